vga_sync_gen: RTL and testbench

- Generates VGA timing and pixel coordinates for the pixel-colour generators: drives x/y into the square/bar generators and takes their 12-bit colour back.
- Registers that colour together with hsync/vsync and applies blanking, so the board VGA connector sees aligned sync and RGB.
- Sits between the system clock and the VGA pins.
- Default parameters give 640x480 @ 60 Hz from a 100 MHz clock.

---
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, and a one-pixel
// output pipeline that keeps hsync, vsync and blanked RGB aligned at the connector.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic [10:0]      h_cnt_q, h_cnt_d;
  logic [10:0]      v_cnt_q, v_cnt_d;
  logic             frame_q, frame_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;

  assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    tick_d    = (div_cnt_q == DIV_LAST);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    frame_d   = 1'b0;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    if (tick_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
          frame_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
      // Sync and colour describe the pixel being left, so they lag x/y by one pixel.
      hsync_d = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vsync_d = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      rgb_d   = video_on ? rgb_in : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      frame_q   <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 12'h000;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      frame_q   <= frame_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign pixel_tick  = tick_q;
  assign frame_start = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-timing instances compared every clock
// against an arithmetic model that derives all outputs from the edge count.
module tb_vga_sync_gen;

  localparam int A_D = 4, A_HD = 8, A_HFP = 2, A_HSY = 3, A_HBP = 2;
  localparam int A_VD = 5, A_VFP = 2, A_VSY = 2, A_VBP = 1;
  localparam int A_FRAME = A_D * (A_HD + A_HFP + A_HSY + A_HBP) * (A_VD + A_VFP + A_VSY + A_VBP);
  localparam int B_D = 1, B_HD = 8, B_HFP = 2, B_HSY = 2, B_HBP = 2;
  localparam int B_VD = 4, B_VFP = 1, B_VSY = 1, B_VBP = 1;
  localparam int B_FRAME = 98;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        tick;
    logic        von;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  localparam exp_t RST_EXP = {11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmode = 1'b0;
  int unsigned seed;
  int          ecnt;
  int          checks = 0;
  int          errors = 0;

  logic [10:0] xa, ya, xb, yb;
  logic        ticka, vona, fsa, hsa, vsa, tickb, vonb, fsb, hsb, vsb;
  logic [11:0] rgba_in, rgba_out, rgbb_in, rgbb_out;
  exp_t        obs_a, obs_b;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  function automatic logic [11:0] colour(input logic [10:0] px, input logic [10:0] py,
                                         input logic cm, input int unsigned sd);
    if (cm) return 12'hABC;
    return 12'(32'(px) * 37 + 32'(py) * 101 + sd);
  endfunction

  assign rgba_in = colour(xa, ya, cmode, seed);
  assign rgbb_in = colour(xb, yb, cmode, seed);
  assign obs_a = {xa, ya, ticka, vona, fsa, hsa, vsa, rgba_out};
  assign obs_b = {xb, yb, tickb, vonb, fsb, hsb, vsb, rgbb_out};

  vga_sync_gen #(.CLK_DIV(A_D), .H_DISPLAY(A_HD), .H_FP(A_HFP), .H_SYNC(A_HSY), .H_BP(A_HBP),
                 .V_DISPLAY(A_VD), .V_FP(A_VFP), .V_SYNC(A_VSY), .V_BP(A_VBP)) dut_a (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgba_in), .x(xa), .y(ya), .pixel_tick(ticka),
    .video_on(vona), .frame_start(fsa), .hsync(hsa), .vsync(vsa), .rgb_out(rgba_out));

  vga_sync_gen #(.CLK_DIV(B_D), .H_DISPLAY(B_HD), .H_FP(B_HFP), .H_SYNC(B_HSY), .H_BP(B_HBP),
                 .V_DISPLAY(B_VD), .V_FP(B_VFP), .V_SYNC(B_VSY), .V_BP(B_VBP)) dut_b (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgbb_in), .x(xb), .y(yb), .pixel_tick(tickb),
    .video_on(vonb), .frame_start(fsb), .hsync(hsb), .vsync(vsb), .rgb_out(rgbb_out));

  // Edge e (counted from reset release) has performed (e-1)/d pixel advances;
  // position, sync and colour follow from that pixel index by plain arithmetic.
  function automatic exp_t model(input int d, input int hd, input int hfp, input int hsy,
                                 input int hbp, input int vd, input int vfp, input int vsy,
                                 input int vbp, input int e, input logic cm, input int unsigned sd);
    exp_t r;
    int ht, vt, tot, n, p, q, hx, hy;
    ht = hd + hfp + hsy + hbp;
    vt = vd + vfp + vsy + vbp;
    tot = ht * vt;
    n = (e >= 1) ? (e - 1) / d : 0;
    p = n % tot;
    r.x = 11'(p % ht);
    r.y = 11'(p / ht);
    r.tick = (e >= 1) && (e % d == 0);
    r.von = ((p % ht) < hd) && ((p / ht) < vd);
    r.fs = (e >= 2) && ((e - 1) % d == 0) && (p == 0);
    if (n == 0) begin
      r.hs = 1'b1;
      r.vs = 1'b1;
      r.rgb = 12'h000;
    end else begin
      q = (n - 1) % tot;
      hx = q % ht;
      hy = q / ht;
      r.hs = !((hx >= hd + hfp) && (hx < hd + hfp + hsy));
      r.vs = !((hy >= vd + vfp) && (hy < vd + vfp + vsy));
      r.rgb = (hx < hd && hy < vd) ? colour(11'(hx), 11'(hy), cm, sd) : 12'h000;
    end
    return r;
  endfunction

  function automatic exp_t model_a(input int e);
    return model(A_D, A_HD, A_HFP, A_HSY, A_HBP, A_VD, A_VFP, A_VSY, A_VBP, e, cmode, seed);
  endfunction

  function automatic exp_t model_b(input int e);
    return model(B_D, B_HD, B_HFP, B_HSY, B_HBP, B_VD, B_VFP, B_VSY, B_VBP, e, cmode, seed);
  endfunction

  task automatic hold_and_release(input logic cm);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    cmode = cm;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs_a !== RST_EXP) begin
      errors++;
      $display("FAIL reset_a got %h want %h", obs_a, RST_EXP);
    end
    checks++;
    if (obs_b !== RST_EXP) begin
      errors++;
      $display("FAIL reset_b got %h want %h", obs_b, RST_EXP);
    end
  endtask

  task automatic test_startup();
    exp_t ea;
    int ticks = 0;
    hold_and_release(1'b0);
    repeat (10) begin
      @(negedge clk);
      ea = model_a(ecnt);
      if (ticka === 1'b1) ticks++;
      checks++;
      if (ticka !== ea.tick || xa !== ea.x || hsa !== 1'b1 || vsa !== 1'b1) begin
        errors++;
        $display("FAIL startup e=%0d got tick=%b x=%0d hs=%b vs=%b want tick=%b x=%0d hs=1 vs=1",
                 ecnt, ticka, xa, hsa, vsa, ea.tick, ea.x);
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL startup_tick_count got %0d want 2", ticks);
    end
  endtask

  task automatic test_full_frames(input int cycles);
    exp_t ea, eb;
    repeat (cycles) begin
      @(negedge clk);
      ea = model_a(ecnt);
      eb = model_b(ecnt);
      checks++;
      if (obs_a !== ea) begin
        errors++;
        $display("FAIL frame_a e=%0d got x=%0d y=%0d t=%b v=%b fs=%b hs=%b vs=%b rgb=%h want x=%0d y=%0d t=%b v=%b fs=%b hs=%b vs=%b rgb=%h",
                 ecnt, obs_a.x, obs_a.y, obs_a.tick, obs_a.von, obs_a.fs, obs_a.hs, obs_a.vs, obs_a.rgb,
                 ea.x, ea.y, ea.tick, ea.von, ea.fs, ea.hs, ea.vs, ea.rgb);
      end
      checks++;
      if (obs_b !== eb) begin
        errors++;
        $display("FAIL frame_b e=%0d got x=%0d y=%0d t=%b v=%b fs=%b hs=%b vs=%b rgb=%h want x=%0d y=%0d t=%b v=%b fs=%b hs=%b vs=%b rgb=%h",
                 ecnt, obs_b.x, obs_b.y, obs_b.tick, obs_b.von, obs_b.fs, obs_b.hs, obs_b.vs, obs_b.rgb,
                 eb.x, eb.y, eb.tick, eb.von, eb.fs, eb.hs, eb.vs, eb.rgb);
      end
    end
  endtask

  task automatic test_frame_spacing();
    int pa[$];
    int pb[$];
    repeat (2 * A_FRAME + 50) begin
      @(negedge clk);
      if (fsa === 1'b1) pa.push_back(ecnt);
      if (fsb === 1'b1) pb.push_back(ecnt);
    end
    checks++;
    if (pa.size() < 2 || pa[1] - pa[0] != A_FRAME) begin
      errors++;
      $display("FAIL frame_spacing_a got %0d pulses gap %0d want gap %0d",
               pa.size(), (pa.size() >= 2) ? pa[1] - pa[0] : -1, A_FRAME);
    end
    checks++;
    if (pb.size() < 2 || pb[1] - pb[0] != B_FRAME) begin
      errors++;
      $display("FAIL frame_spacing_b got %0d pulses gap %0d want gap %0d",
               pb.size(), (pb.size() >= 2) ? pb[1] - pb[0] : -1, B_FRAME);
    end
  endtask

  task automatic test_blanking();
    exp_t ea;
    hold_and_release(1'b1);
    repeat (A_FRAME + 20) begin
      @(negedge clk);
      ea = model_a(ecnt);
      checks++;
      if (rgba_out !== ea.rgb) begin
        errors++;
        $display("FAIL blank_rgb e=%0d x=%0d y=%0d got %h want %h", ecnt, xa, ya, rgba_out, ea.rgb);
      end
      if (ecnt == A_D + 1) begin
        checks++;
        if (rgba_out !== 12'hABC) begin
          errors++;
          $display("FAIL first_pixel_rgb got %h want abc", rgba_out);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int tx, ty, n;
    bit found;
    exp_t ea, eb;
    tx = $urandom_range(0, A_HD + A_HFP + A_HSY + A_HBP - 1);
    ty = $urandom_range(0, A_VD + A_VFP + A_VSY + A_VBP - 1);
    found = 0;
    n = 0;
    while (!found && n < A_FRAME + 10) begin
      @(negedge clk);
      n++;
      if (xa == 11'(tx) && ya == 11'(ty)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_wait got no x=%0d y=%0d within %0d clks", tx, ty, n);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== RST_EXP || obs_b !== RST_EXP) begin
      errors++;
      $display("FAIL async_reset got a=%h b=%h want %h", obs_a, obs_b, RST_EXP);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat ($urandom_range(2 * A_D + 1, 40)) begin
      @(negedge clk);
      ea = model_a(ecnt);
      eb = model_b(ecnt);
      checks++;
      if (obs_a !== ea || obs_b !== eb) begin
        errors++;
        $display("FAIL after_reset e=%0d got a=%h b=%h want a=%h b=%h", ecnt, obs_a, obs_b, ea, eb);
      end
    end
  endtask

  initial begin
    seed = $urandom;
    #1 reset_n = 1'b0;
    test_reset();
    test_startup();
    test_full_frames(2 * A_FRAME + 20);
    test_frame_spacing();
    test_blanking();
    cmode = 1'b0;
    for (int i = 0; i < 4; i++) test_mid_reset();
    test_full_frames($urandom_range(100, 300));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
